sva_burst_sequencer: RTL and testbench
======================================

// Module: sva_burst_sequencer
// PURPOSE
//   Sequences a simple burst datapath driving valid/data/addr. Each accepted req
//   starts one burst of beats with incrementing address and data; enable gates progress.
//   busy marks the whole transaction. Drives the signal set checked by the SVA
//   system-function tests, so every property there holds by construction.
// PARAMETERS
//   DATA_W     8   width of data beat
//   ADDR_W     8   width of address
//   LEN_W      4   width of burst_len; beats per burst = burst_len+1
//   ADDR_STEP  1   address increment per beat (modulo 2**ADDR_W)
// PORTS
//   clk         in   1        rising-edge clock
//   reset_n     in   1        asynchronous active-low reset
//   req         in   1        burst request; sampled only in IDLE
//   enable      in   1        beat gate; 0 = stall, outputs hold
//   start_addr  in   ADDR_W   first beat address, latched with req
//   start_data  in   DATA_W   first beat data, latched with req
//   burst_len   in   LEN_W    beats-1, latched with req
//   valid       out  1        beat present on data/addr this cycle
//   data        out  DATA_W   beat data
//   addr        out  ADDR_W   beat address
//   busy        out  1        transaction in progress (state != IDLE)
//   done        out  1        one-cycle pulse after last beat
//   state_oh    out  4        one-hot state {DONE,BURST,LOAD,IDLE}
// BEHAVIOUR
//   - reset_n low (async, any state): state=IDLE; valid=0, data=0, addr=0,
//     busy=0, done=0, state_oh=4'b0001. All outputs are registered.
//   - IDLE: req=1 at edge -> latch start_*/burst_len, go LOAD. req=0 -> stay.
//   - LOAD: one cycle, valid=0; addr<=start_addr, data<=start_data,
//     beat counter<=burst_len. -> BURST.
//   - BURST, enable=1: valid=1, current addr/data presented; next edge
//     addr+=ADDR_STEP, data+=1 (both wrap modulo width). Counter 0 on a
//     presented beat -> DONE next cycle, else counter-=1.
//   - BURST, enable=0: valid=0; addr, data, counter hold (stable).
//   - enable toggles only stall; a beat counts only when valid=1.
//   - DONE: one cycle, done=1, valid=0, addr/data hold -> IDLE.
//   - busy=1 in LOAD/BURST/DONE; rises edge after req accept, falls entering IDLE.
//   - req while busy is ignored (no queueing); a new burst needs req high in IDLE,
//     so minimum back-to-back gap is DONE + IDLE = 2 cycles between bursts.
//   - burst_len=0 -> exactly 1 beat; burst_len=max -> 2**LEN_W beats.
//   - Consecutive valid beats satisfy data == prev_beat_data+1 (mod 2**DATA_W).
//   - Latency: req sampled at edge N -> first valid at earliest edge N+2.
//   - Reset mid-burst aborts immediately; no done pulse.
// CONFIGURATION
//   SVA_SEQ_CHECK_EN defined: embed concurrent assertions @(posedge clk)
//     disable iff (!reset_n): $onehot(state_oh); $rose(busy) |-> !valid;
//     !enable && valid-state |=> $stable(addr) && $stable(data);
//     valid && $past(valid) |-> data == $past(data)+1; $rose(done) |=> !busy;
//     !$isunknown({valid,busy,done}).
//   Not defined: no assertion code, identical RTL behaviour and ports.
// TESTING
//   1 reset: reset_n=0 mid-stream -> all outputs 0, state_oh=0001 same cycle.
//   2 req=1, start_addr=8'h10, start_data=8'h05, burst_len=3, enable=1 ->
//     4 beats addr 10,11,12,13 data 05,06,07,08, then done pulse, busy drops.
//   3 same burst, enable=0 on 2nd beat for 3 cycles -> valid=0, addr=11,
//     data=06 held; resumes, still 4 beats total.
//   4 start_addr=8'hFE, start_data=8'hFF, burst_len=2 -> addr FE,FF,00;
//     data FF,00,01 (wrap).
//   5 burst_len=0 -> single beat then done; req pulsed during BURST -> ignored,
//     no second burst.
//   6 rebuild with SVA_SEQ_CHECK_EN, run 2-5 -> zero assertion failures.

Source files
------------

// File: rtl/sva_burst_sequencer.sv
// sva_burst_sequencer
//   Each req accepted in IDLE starts one burst of burst_len+1 beats. Each beat has
//   an incrementing address and data. enable stalls beat delivery. busy covers the
//   whole transaction, and done pulses for one cycle after the last beat.
//   Optional build macro: SVA_SEQ_CHECK_EN embeds concurrent assertions on the
//   output signal set. Ports and behaviour are the same with or without it.
// Ports
//   clk, reset_n            : clock, asynchronous active-low reset
//   req                     : burst request, sampled only in IDLE
//   enable                  : beat gate (0 = stall, outputs hold)
//   start_addr/start_data   : first beat address/data, latched with req
//   burst_len               : beats-1, latched with req
//   valid/data/addr         : registered beat outputs
//   busy/done               : transaction in progress / end-of-burst pulse
//   state_oh                : one-hot state {DONE,BURST,LOAD,IDLE}
module sva_burst_sequencer #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned LEN_W     = 4,
  parameter int unsigned ADDR_STEP = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic              enable,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [DATA_W-1:0] start_data,
  input  logic [LEN_W-1:0]  burst_len,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [ADDR_W-1:0] addr,
  output logic              busy,
  output logic              done,
  output logic [3:0]        state_oh
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_BURST, S_DONE} state_t;

  state_t            r_state,  w_state_nxt;
  logic [ADDR_W-1:0] r_saddr,  w_saddr_nxt;
  logic [DATA_W-1:0] r_sdata,  w_sdata_nxt;
  logic [LEN_W-1:0]  r_len,    w_len_nxt;
  logic [ADDR_W-1:0] r_addr,   w_addr_nxt;
  logic [DATA_W-1:0] r_data,   w_data_nxt;
  logic [LEN_W-1:0]  r_cnt,    w_cnt_nxt;
  logic              r_valid,  w_valid_nxt;
  logic              r_done,   w_done_nxt;
  logic              r_busy,   w_busy_nxt;
  logic [3:0]        r_oh,     w_oh_nxt;

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_saddr <= '0;
      r_sdata <= '0;
      r_len   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_oh    <= 4'b0001;
    end else begin
      r_state <= w_state_nxt;
      r_saddr <= w_saddr_nxt;
      r_sdata <= w_sdata_nxt;
      r_len   <= w_len_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
      r_cnt   <= w_cnt_nxt;
      r_valid <= w_valid_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= w_busy_nxt;
      r_oh    <= w_oh_nxt;
    end
  end

  // Next state and next outputs
  always_comb begin
    w_state_nxt = r_state;
    w_saddr_nxt = r_saddr;
    w_sdata_nxt = r_sdata;
    w_len_nxt   = r_len;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_cnt_nxt   = r_cnt;
    w_valid_nxt = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          w_saddr_nxt = start_addr;
          w_sdata_nxt = start_data;
          w_len_nxt   = burst_len;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_addr_nxt  = r_saddr;
        w_data_nxt  = r_sdata;
        w_cnt_nxt   = r_len;
        w_valid_nxt = enable;
        w_state_nxt = S_BURST;
      end
      S_BURST: begin
        // r_valid means a beat was presented this cycle, so it is consumed at this edge.
        if (r_valid && (r_cnt == '0)) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_valid_nxt = enable;
          if (r_valid) begin
            w_addr_nxt = r_addr + ADDR_W'(ADDR_STEP);
            w_data_nxt = r_data + DATA_W'(1);
            w_cnt_nxt  = r_cnt - LEN_W'(1);
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
    case (w_state_nxt)
      S_IDLE:  w_oh_nxt = 4'b0001;
      S_LOAD:  w_oh_nxt = 4'b0010;
      S_BURST: w_oh_nxt = 4'b0100;
      default: w_oh_nxt = 4'b1000;
    endcase
  end

  assign valid    = r_valid;
  assign data     = r_data;
  assign addr     = r_addr;
  assign busy     = r_busy;
  assign done     = r_done;
  assign state_oh = r_oh;

`ifdef SVA_SEQ_CHECK_EN
  // Protocol properties of the output signal set
  a_onehot: assert property (@(posedge clk) disable iff (!reset_n) $onehot(state_oh));
  a_rose_busy: assert property (@(posedge clk) disable iff (!reset_n) $rose(busy) |-> !valid);
  a_stall_stable: assert property (@(posedge clk) disable iff (!reset_n)
    (!enable && state_oh[2] && !valid) |=> ($stable(addr) && $stable(data)));
  a_data_inc: assert property (@(posedge clk) disable iff (!reset_n)
    (valid && $past(valid)) |-> (data == $past(data) + DATA_W'(1)));
  a_done_idle: assert property (@(posedge clk) disable iff (!reset_n) $rose(done) |=> !busy);
  a_known: assert property (@(posedge clk) disable iff (!reset_n) !$isunknown({valid, busy, done}));
`else
  // Assertions are excluded from this build.
`endif

endmodule

// File: tb/tb_sva_burst_sequencer.sv
// Testbench for sva_burst_sequencer.
//   It applies directed bursts and randomized bursts, and compares every cycle
//   against a beat-level model. Beat k of a burst has address start_addr+k*ADDR_STEP
//   and data start_data+k. A burst ends one done cycle after the beat with k=burst_len.
module tb_sva_burst_sequencer;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned LEN_W     = 4;
  localparam int unsigned ADDR_STEP = 1;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              req;
  logic              enable;
  logic [ADDR_W-1:0] start_addr;
  logic [DATA_W-1:0] start_data;
  logic [LEN_W-1:0]  burst_len;
  logic              valid;
  logic [DATA_W-1:0] data;
  logic [ADDR_W-1:0] addr;
  logic              busy;
  logic              done;
  logic [3:0]        state_oh;

  int checks = 0;
  int errors = 0;

  sva_burst_sequencer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .ADDR_STEP(ADDR_STEP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .enable(enable),
    .start_addr(start_addr), .start_data(start_data), .burst_len(burst_len),
    .valid(valid), .data(data), .addr(addr), .busy(busy), .done(done),
    .state_oh(state_oh)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [ADDR_W-1:0] exp_addr(input logic [ADDR_W-1:0] sa, input int k);
    return ADDR_W'(int'(sa) + k * int'(ADDR_STEP));
  endfunction

  function automatic logic [DATA_W-1:0] exp_data(input logic [DATA_W-1:0] sd, input int k);
    return DATA_W'(int'(sd) + k);
  endfunction

  // enable for the j-th edge after LOAD: random (mode 1) or high except edges lo..hi
  function automatic logic gen_en(input int mode, input int j, input int lo, input int hi);
    if (mode == 1) return ($urandom_range(0, 3) != 0);
    return !(j >= lo && j <= hi);
  endfunction

  task automatic run_burst(input logic [ADDR_W-1:0] sa, input logic [DATA_W-1:0] sd,
                           input logic [LEN_W-1:0] len, input int mode, input int lo,
                           input int hi, input bit req_noise);
    int   n;
    int   k;
    int   j;
    int   cyc;
    bit   fin;
    logic prev_en;
    n = int'(len) + 1;
    k = 0;
    j = 0;
    cyc = 0;
    fin = 1'b0;
    check("pre_idle_busy", 32'(busy), 0);
    req        = 1'b1;
    start_addr = sa;
    start_data = sd;
    burst_len  = len;
    enable     = 1'($urandom_range(0, 1));
    step();
    check("load_busy",  32'(busy), 1);
    check("load_valid", 32'(valid), 0);
    check("load_done",  32'(done), 0);
    check("load_oh",    32'(state_oh), 32'h2);
    // Scramble the start inputs so that the bench exercises the request latch.
    req        = req_noise ? 1'($urandom_range(0, 1)) : 1'b0;
    start_addr = ADDR_W'($urandom);
    start_data = DATA_W'($urandom);
    burst_len  = LEN_W'($urandom);
    prev_en    = gen_en(mode, j, lo, hi);
    enable     = prev_en;
    while (!fin) begin
      step();
      j++;
      cyc++;
      if (k == n) begin
        check("done_pulse", 32'(done), 1);
        check("done_valid", 32'(valid), 0);
        check("done_busy",  32'(busy), 1);
        check("done_oh",    32'(state_oh), 32'h8);
        check("done_addr",  32'(addr), 32'(exp_addr(sa, n - 1)));
        check("done_data",  32'(data), 32'(exp_data(sd, n - 1)));
        fin = 1'b1;
      end else begin
        check("beat_valid", 32'(valid), 32'(prev_en));
        check("beat_addr",  32'(addr), 32'(exp_addr(sa, k)));
        check("beat_data",  32'(data), 32'(exp_data(sd, k)));
        check("beat_busy",  32'(busy), 1);
        check("beat_done",  32'(done), 0);
        check("beat_oh",    32'(state_oh), 32'h4);
        if (prev_en) k++;
      end
      if (!fin && cyc >= 200) begin
        check("burst_timeout", 32'(cyc), 0);
        fin = 1'b1;
      end
      req     = req_noise ? 1'($urandom_range(0, 1)) : 1'b0;
      prev_en = gen_en(mode, j, lo, hi);
      enable  = prev_en;
    end
    step();
    check("idle_busy",  32'(busy), 0);
    check("idle_done",  32'(done), 0);
    check("idle_valid", 32'(valid), 0);
    check("idle_oh",    32'(state_oh), 32'h1);
    check("idle_addr",  32'(addr), 32'(exp_addr(sa, n - 1)));
    check("idle_data",  32'(data), 32'(exp_data(sd, n - 1)));
    req    = 1'b0;
    enable = 1'($urandom_range(0, 1));
    step();
    check("no_requeue_busy", 32'(busy), 0);
    check("no_requeue_oh",   32'(state_oh), 32'h1);
  endtask

  initial begin
    reset_n    = 1'b0;
    req        = 1'b0;
    enable     = 1'b0;
    start_addr = '0;
    start_data = '0;
    burst_len  = '0;
    step();
    step();
    check("rst_valid", 32'(valid), 0);
    check("rst_data",  32'(data), 0);
    check("rst_addr",  32'(addr), 0);
    check("rst_busy",  32'(busy), 0);
    check("rst_done",  32'(done), 0);
    check("rst_oh",    32'(state_oh), 32'h1);
    #3 reset_n = 1'b1;
    step();

    // Directed bursts: plain, stalled on the second beat, wrapping, single beat with req noise
    run_burst(8'h10, 8'h05, 4'd3, 0, 1, 0, 1'b0);
    run_burst(8'h10, 8'h05, 4'd3, 0, 1, 3, 1'b0);
    run_burst(8'hFE, 8'hFF, 4'd2, 0, 1, 0, 1'b0);
    run_burst(8'h40, 8'h80, 4'd0, 0, 1, 0, 1'b1);
    run_burst(8'($urandom), 8'($urandom), 4'hF, 1, 0, 0, 1'b1);

    // Randomized bursts
    for (int i = 0; i < 20; i++) begin
      run_burst(8'($urandom), 8'($urandom), 4'($urandom), 1, 0, 0, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a burst aborts it immediately, with no done pulse
    req        = 1'b1;
    start_addr = 8'h20;
    start_data = 8'h30;
    burst_len  = 4'd7;
    enable     = 1'b1;
    step();
    req = 1'b0;
    step();
    step();
    step();
    check("mid_busy_before_rst", 32'(busy), 1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(valid), 0);
    check("mid_rst_data",  32'(data), 0);
    check("mid_rst_addr",  32'(addr), 0);
    check("mid_rst_busy",  32'(busy), 0);
    check("mid_rst_done",  32'(done), 0);
    check("mid_rst_oh",    32'(state_oh), 32'h1);
    step();
    #3 reset_n = 1'b1;
    step();
    check("post_rst_busy", 32'(busy), 0);
    check("post_rst_done", 32'(done), 0);
    check("post_rst_oh",   32'(state_oh), 32'h1);
    run_burst(8'h7F, 8'h01, 4'd1, 1, 0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
